// File: rtl/timer_display.sv
// rtl/timer_display.sv - clamps elapsed seconds, converts to BCD by double-dabble, drives three active-low 7-seg digits
module timer_display #(
    parameter int BLANK_LEADING = 1,
    parameter int MAX_SHOW      = 999
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [9:0]  time_in,
    input  logic        freeze,
    output logic [11:0] bcd,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic        busy,
    output logic        upd
);

    localparam logic [9:0] MAX_VAL    = 10'(MAX_SHOW);
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_ZERO   = 7'h40;
    localparam logic [6:0] LEAD_RESET = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_ZERO;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t      state, state_next;
    logic [9:0]  last_val;
    logic [21:0] sr;
    logic [21:0] sr_adj;
    logic [3:0]  bit_cnt;
    logic [9:0]  clamped;
    logic        start;
    logic        blank2, blank1;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        clamped = (time_in > MAX_VAL) ? MAX_VAL : time_in;
        start   = (state == IDLE) && !freeze && (time_in != last_val);
        // Pre-shift correction of each BCD nibble; binary bits pass through untouched.
        sr_adj  = {add3(sr[21:18]), add3(sr[17:14]), add3(sr[13:10]), sr[9:0]};
        blank2  = (BLANK_LEADING != 0) && (sr[21:18] == 4'd0);
        blank1  = blank2 && (sr[17:14] == 4'd0);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (bit_cnt == 4'd9) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            last_val <= '0;
            sr       <= '0;
            bit_cnt  <= '0;
            bcd      <= '0;
            HEX0     <= SEG_ZERO;
            HEX1     <= LEAD_RESET;
            HEX2     <= LEAD_RESET;
            busy     <= 1'b0;
            upd      <= 1'b0;
        end else begin
            upd  <= 1'b0;
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        last_val <= time_in;
                        sr       <= {12'b0, clamped};
                        bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    sr      <= sr_adj << 1;
                    bit_cnt <= bit_cnt + 4'd1;
                end
                UPDATE: begin
                    bcd  <= sr[21:10];
                    HEX2 <= blank2 ? SEG_BLANK : seg(sr[21:18]);
                    HEX1 <= blank1 ? SEG_BLANK : seg(sr[17:14]);
                    HEX0 <= seg(sr[13:10]);
                    upd  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_display.sv
// tb/tb_timer_display.sv - table-driven bench for timer_display (blanked and unblanked instances)
module tb_timer_display;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [9:0]  time_in;
    logic        freeze;
    logic [11:0] bcd_b, bcd_n;
    logic [6:0]  h0_b, h1_b, h2_b, h0_n, h1_n, h2_n;
    logic        busy_b, busy_n, upd_b, upd_n;

    int checks   = 0;
    int failures = 0;
    int upd_cnt  = 0;
    int busy_cnt = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    timer_display #(.BLANK_LEADING(1), .MAX_SHOW(999)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .time_in(time_in), .freeze(freeze),
        .bcd(bcd_b), .HEX0(h0_b), .HEX1(h1_b), .HEX2(h2_b), .busy(busy_b), .upd(upd_b));

    timer_display #(.BLANK_LEADING(0), .MAX_SHOW(999)) dut_n (
        .CLOCK_50(CLOCK_50), .reset(reset), .time_in(time_in), .freeze(freeze),
        .bcd(bcd_n), .HEX0(h0_n), .HEX1(h1_n), .HEX2(h2_n), .busy(busy_n), .upd(upd_n));

    always @(negedge CLOCK_50) begin
        if (upd_b)  upd_cnt  = upd_cnt + 1;
        if (busy_b) busy_cnt = busy_cnt + 1;
    end

    typedef struct {
        int        tin;
        int        exp_bcd;
        logic [6:0] h2, h1, h0;
        logic [6:0] n2, n1;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Counts negedges from the first one after the sampling edge until upd; 0 if it never comes.
    task automatic wait_upd(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLOCK_50);
            if (upd_b) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bcd"},  int'(bcd_b),  0);
        chk({tag, "_hex0"}, int'(h0_b),   'h40);
        chk({tag, "_hex1"}, int'(h1_b),   'h7F);
        chk({tag, "_hex2"}, int'(h2_b),   'h7F);
        chk({tag, "_busy"}, int'(busy_b), 0);
        chk({tag, "_upd"},  int'(upd_b),  0);
        chk({tag, "_n_hex2"}, int'(h2_n), 'h40);
    endtask

    initial begin
        int lat, u0, b0;

        vecs[0] = '{123,  'h123, 7'h79, 7'h24, 7'h30, 7'h79, 7'h24};
        vecs[1] = '{1000, 'h999, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
        vecs[2] = '{1023, 'h999, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
        vecs[3] = '{999,  'h999, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
        vecs[4] = '{7,    'h007, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40};
        vecs[5] = '{40,   'h040, 7'h7F, 7'h19, 7'h40, 7'h40, 7'h19};
        vecs[6] = '{105,  'h105, 7'h79, 7'h40, 7'h12, 7'h79, 7'h40};
        vecs[7] = '{0,    'h000, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40};
        vecs[8] = '{250,  'h250, 7'h24, 7'h12, 7'h40, 7'h24, 7'h12};

        reset = 1'b1; time_in = '0; freeze = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        check_reset_vals("rst");
        u0 = upd_cnt; b0 = busy_cnt;
        repeat (20) @(negedge CLOCK_50);
        chk("idle_hold_upd",  upd_cnt - u0,  0);
        chk("idle_hold_busy", busy_cnt - b0, 0);
        chk("idle_hold_bcd",  int'(bcd_b),   0);

        foreach (vecs[i]) begin
            u0 = upd_cnt;
            time_in = 10'(vecs[i].tin);
            @(negedge CLOCK_50);
            chk($sformatf("v%0d_busy", i), int'(busy_b), 1);
            wait_upd(lat);
            chk($sformatf("v%0d_latency", i), lat + 1, 12);
            chk($sformatf("v%0d_bcd", i),  int'(bcd_b), vecs[i].exp_bcd);
            chk($sformatf("v%0d_hex2", i), int'(h2_b),  int'(vecs[i].h2));
            chk($sformatf("v%0d_hex1", i), int'(h1_b),  int'(vecs[i].h1));
            chk($sformatf("v%0d_hex0", i), int'(h0_b),  int'(vecs[i].h0));
            chk($sformatf("v%0d_n_bcd", i),  int'(bcd_n), vecs[i].exp_bcd);
            chk($sformatf("v%0d_n_hex2", i), int'(h2_n),  int'(vecs[i].n2));
            chk($sformatf("v%0d_n_hex1", i), int'(h1_n),  int'(vecs[i].n1));
            chk($sformatf("v%0d_n_hex0", i), int'(h0_n),  int'(vecs[i].h0));
            repeat (4) @(negedge CLOCK_50);
            chk($sformatf("v%0d_upd_pulses", i), upd_cnt - u0, 1);
            chk($sformatf("v%0d_busy_after", i), int'(busy_b), 0);
        end

        // Input changes mid-conversion: both values are shown in turn.
        u0 = upd_cnt;
        time_in = 10'd5;
        repeat (3) @(negedge CLOCK_50);
        time_in = 10'd6;
        wait_upd(lat);
        chk("mid_first_latency", lat + 3, 12);
        chk("mid_first_bcd", int'(bcd_b), 'h005);
        wait_upd(lat);
        chk("mid_second_latency", lat, 12);
        chk("mid_second_bcd", int'(bcd_b), 'h006);
        repeat (20) @(negedge CLOCK_50);
        chk("mid_upd_pulses", upd_cnt - u0, 2);

        // Freeze holds the display; release converts the latest value once.
        time_in = 10'd10;
        wait_upd(lat);
        chk("frz_pre_bcd", int'(bcd_b), 'h010);
        repeat (2) @(negedge CLOCK_50);
        freeze = 1'b1;
        u0 = upd_cnt; b0 = busy_cnt;
        time_in = 10'd11;
        repeat (5) @(negedge CLOCK_50);
        time_in = 10'd12;
        repeat (20) @(negedge CLOCK_50);
        chk("frz_busy", busy_cnt - b0, 0);
        chk("frz_upd",  upd_cnt - u0,  0);
        chk("frz_bcd",  int'(bcd_b),   'h010);
        chk("frz_hex1", int'(h1_b),    'h79);
        freeze = 1'b0;
        wait_upd(lat);
        chk("frz_rel_bcd", int'(bcd_b), 'h012);
        repeat (20) @(negedge CLOCK_50);
        chk("frz_rel_pulses", upd_cnt - u0, 1);

        // Freeze raised mid-conversion does not abort it.
        time_in = 10'd20;
        repeat (3) @(negedge CLOCK_50);
        freeze = 1'b1;
        wait_upd(lat);
        chk("frz_mid_latency", lat + 3, 12);
        chk("frz_mid_bcd", int'(bcd_b), 'h020);
        freeze = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        // Reset during SHIFT abandons the conversion with no upd pulse.
        u0 = upd_cnt;
        time_in = 10'd77;
        repeat (5) @(negedge CLOCK_50);
        chk("rst_mid_busy", int'(busy_b), 1);
        reset = 1'b1; time_in = '0;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check_reset_vals("rst_mid");
        repeat (20) @(negedge CLOCK_50);
        chk("rst_mid_upd", upd_cnt - u0, 0);
        chk("rst_mid_bcd_hold", int'(bcd_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_display.md
# timer_display

Downstream consumer of the one-second game timer. Takes the 10-bit elapsed-seconds value, clamps it to 999, and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. Drives three active-low seven-segment displays, with optional leading-zero blanking. Conversion runs only when the input value changes. A freeze input holds the displayed time, for example at game over.

## Interface
Parameters:
- BLANK_LEADING, 1: 1 = blank leading zero digits (units digit is never blanked); 0 = show all three digits.
- MAX_SHOW, 999: saturation value; inputs above it display as MAX_SHOW.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- time_in  in  10  elapsed seconds, unsigned binary.
- freeze  in  1  when high, no new conversion starts; display holds.
- bcd  out  12  {hundreds, tens, units} BCD, registered.
- HEX0  out  7  units segments, active-low, bit order {g,f,e,d,c,b,a}.
- HEX1  out  7  tens segments.
- HEX2  out  7  hundreds segments.
- busy  out  1  high while a conversion is in progress.
- upd  out  1  one-cycle pulse when bcd/HEX outputs change.

## Operation
- FSM states are IDLE, SHIFT and UPDATE. Reset state is IDLE.
- IDLE:
  - If freeze=0 and time_in != last_val: set last_val<=time_in.
  - Load shift register {12'b0, clamp(time_in)}, where clamp(x) = (x > MAX_SHOW) ? MAX_SHOW : x, 10 bits.
  - Set bit counter to 0 and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: one bit per cycle. Each BCD nibble >= 5 gets +3 (4-bit add, no carry out), then the whole 22-bit register shifts left by 1. After the 10th shift, go to UPDATE.
- UPDATE:
  - bcd <= register[21:10].
  - Drive HEX2/1/0 from the new digits.
  - upd=1 for this cycle; return to IDLE.
- busy=1 in SHIFT and UPDATE, 0 in IDLE.
- Segment codes (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- Blanking with BLANK_LEADING=1:
  - HEX2 blank when hundreds=0.
  - HEX1 blank when hundreds=0 and tens=0.
  - HEX0 is never blank.
- time_in changes while busy=1 are not sampled. The final value is picked up on the first IDLE cycle after UPDATE. No value is lost if the input is stable for at least 12 cycles.
- Asserting freeze mid-conversion does not abort it; the conversion completes and updates the display. freeze only gates new starts.
- Deasserting freeze: if time_in differs from last_val, conversion starts on the next IDLE edge.

## Timing
- Reset values:
  - State IDLE; last_val=0; bcd=12'h000; busy=0; upd=0.
  - HEX0=7'h40.
  - HEX1 and HEX2 = 7'h7F if BLANK_LEADING=1, else 7'h40.
- Let edge k be the first clock edge at which IDLE samples a changed time_in with freeze=0.
  - Edges k+1..k+10 perform SHIFT.
  - Edge k+11 is UPDATE: outputs change and upd is high during the cycle after edge k+11.
  - busy is high from after edge k through edge k+11.
  - Latency is 12 cycles from the sampled change to the visible output.
- reset asserted in any state: next edge forces the reset values, abandoning any conversion without an upd pulse.
- reset has priority over every other input.
- All outputs are registered; there is no combinational path from time_in/freeze to any output.
- Inputs arrive in the CLOCK_50 domain; no synchronisers are needed.

## Test plan
- Reset, hold time_in=0 for 20 cycles: bcd=000, HEX0=40, HEX1=HEX2=7F, busy=0, upd never pulses.
- time_in 0->123: busy rises on the next edge; exactly 12 cycles later bcd=12'h123, HEX2=79, HEX1=24, HEX0=30, single upd pulse.
- time_in=1000, then 1023: bcd=999, HEX2/1/0=10/10/10 both times (saturation). time_in=999 after 1023 produces no conversion only if last_val=999.
- Blanking, BLANK_LEADING=1:
  - 7 gives HEX2/1/0 = 7F/7F/78.
  - 40 gives 7F/19/40.
  - 105 gives 79/40/12.
  - Rerun with BLANK_LEADING=0: 7 gives 40/40/78.
- time_in 5 then 6 three cycles later (mid-conversion): first upd shows 005; a second conversion starts on the first IDLE edge and the next upd shows 006; exactly two upd pulses.
- freeze=1, time_in 10->11->12: no busy, display holds 10. freeze=0: one conversion, display 12. Reset asserted at SHIFT cycle 5: outputs return to reset values, no upd pulse.
